// File: rtl/my_gemm_tile_if.sv
// Control and BRAM bus bundle for my_gemm_tile: job request/status toward the
// AXI start/done slave plus the single BRAM port used for all operand and result traffic.
interface my_gemm_tile_if #(
  parameter int K_W             = 16,
  parameter int BRAM_ADDR_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int BRAM_WE_WIDTH   = 4
);
  logic                         start;
  logic [K_W-1:0]               k_len;
  logic [BRAM_ADDR_WIDTH-3:0]   a_base;
  logic [BRAM_ADDR_WIDTH-3:0]   b_base;
  logic [BRAM_ADDR_WIDTH-3:0]   c_base;
  logic                         mode_acc;
  logic                         busy;
  logic                         done;
  logic                         err;
  logic [BRAM_ADDR_WIDTH-1:0]   BRAM_ADDR;
  logic [BRAM_DATA_WIDTH-1:0]   BRAM_RDDATA;
  logic [BRAM_DATA_WIDTH-1:0]   BRAM_WRDATA;
  logic [BRAM_WE_WIDTH-1:0]     BRAM_WE;

  modport slave (
    input  start, k_len, a_base, b_base, c_base, mode_acc, BRAM_RDDATA,
    output busy, done, err, BRAM_ADDR, BRAM_WRDATA, BRAM_WE
  );

  modport master (
    output start, k_len, a_base, b_base, c_base, mode_acc, BRAM_RDDATA,
    input  busy, done, err, BRAM_ADDR, BRAM_WRDATA, BRAM_WE
  );
endinterface

// File: rtl/my_gemm_tile.sv
// N x N output-stationary integer MAC tile: C = A*B (or C += A*B), with A, B and C
// streamed through one BRAM port; K is a run-time inner dimension.
module my_gemm_tile #(
  parameter int N               = 8,
  parameter int DATA_W          = 16,
  parameter int ACC_W           = 32,
  parameter int K_W             = 16,
  parameter int RD_LAT          = 1,
  parameter int DONE_LENGTH     = 5,
  parameter int BRAM_ADDR_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int BRAM_WE_WIDTH   = 4
) (
  input  logic S_AXI_ACLK,
  input  logic S_AXI_ARESET,
  output logic BRAM_CLK,
  my_gemm_tile_if.slave bus
);

  localparam int AW    = BRAM_ADDR_WIDTH - 2;
  localparam int NN    = N * N;
  localparam int TAG_W = $clog2(NN);
  localparam int CNT_W = $clog2(NN + 2*N + RD_LAT + DONE_LENGTH + 1);

  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(NN + RD_LAT - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(2*N + RD_LAT - 1);
  localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(NN - 1);
  localparam logic [CNT_W-1:0] DONE_LAST  = CNT_W'(DONE_LENGTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_LOAD, S_MAC, S_WRITE, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [K_W-1:0]            k_q, k_d;

  logic [K_W-1:0]            klen_q;
  logic [AW-1:0]             abase_q, bbase_q, cbase_q;
  logic                      err_q;

  logic signed [ACC_W-1:0]   acc_q [NN];
  logic signed [DATA_W-1:0]  a_q [N];
  logic signed [DATA_W-1:0]  b_q [N];
  logic [RD_LAT-1:0]         rd_vld_q;
  logic [TAG_W-1:0]          rd_tag_q [RD_LAT];

  logic                      accept;
  logic                      k_last;
  logic                      rd_issue;
  logic [AW-1:0]             addr_w;

  function automatic logic signed [ACC_W-1:0] mac_term(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [2*DATA_W-1:0] p;
    p = a * b;
    return ACC_W'(p);
  endfunction

  function automatic logic signed [DATA_W-1:0] operand(input logic [BRAM_DATA_WIDTH-1:0] w);
    return w[DATA_W-1:0];
  endfunction

  assign BRAM_CLK = S_AXI_ACLK;
  assign accept   = (state_q == S_IDLE) && bus.start;
  assign k_last   = (k_q == klen_q - K_W'(1));
  assign rd_issue = ((state_q == S_INIT) && (cnt_q < CNT_W'(NN))) ||
                    ((state_q == S_LOAD) && (cnt_q < CNT_W'(2*N)));

  // State register
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic; cnt_q restarts at zero on every state change
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          k_d = '0;
          if (bus.k_len == '0)    state_d = S_DONE;
          else if (bus.mode_acc)  state_d = S_INIT;
          else                    state_d = S_LOAD;
        end
      end
      S_INIT: if (cnt_q == INIT_LAST) begin state_d = S_LOAD; cnt_d = '0; end
      S_LOAD: if (cnt_q == LOAD_LAST) begin state_d = S_MAC; cnt_d = '0; end
      S_MAC: begin
        cnt_d = '0;
        if (k_last) state_d = S_WRITE;
        else begin
          state_d = S_LOAD;
          k_d     = k_q + K_W'(1);
        end
      end
      S_WRITE: if (cnt_q == WRITE_LAST) begin state_d = S_DONE; cnt_d = '0; end
      S_DONE:  if (cnt_q == DONE_LAST)  begin state_d = S_IDLE; cnt_d = '0; end
      default: begin state_d = S_IDLE; cnt_d = '0; end
    endcase
  end

  // Job parameters are frozen at accept so later input changes cannot leak in
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      klen_q  <= '0;
      abase_q <= '0;
      bbase_q <= '0;
      cbase_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      klen_q  <= bus.k_len;
      abase_q <= bus.a_base;
      bbase_q <= bus.b_base;
      cbase_q <= bus.c_base;
      err_q   <= (bus.k_len == '0);
    end else if ((state_q == S_DONE) && (cnt_q == DONE_LAST)) begin
      err_q   <= 1'b0;
    end
  end

  // Word address: C walk in INIT/WRITE, A column then B row in LOAD
  always_comb begin
    addr_w = cbase_q + AW'(cnt_q);
    if (state_q == S_LOAD) begin
      if (cnt_q < CNT_W'(N))
        addr_w = abase_q + AW'(cnt_q) * AW'(klen_q) + AW'(k_q);
      else
        addr_w = bbase_q + AW'(k_q) * AW'(N) + AW'(cnt_q) - AW'(N);
    end
  end

  // Read-return pipeline: tag i issued now lands RD_LAT cycles later
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rd_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) rd_tag_q[i] <= '0;
      for (int i = 0; i < NN; i++)     acc_q[i]    <= '0;
      for (int i = 0; i < N; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_tag_q[i] <= rd_tag_q[i-1];
      end
      rd_vld_q[0] <= rd_issue;
      rd_tag_q[0] <= cnt_q[TAG_W-1:0];

      if (accept && !bus.mode_acc) begin
        for (int i = 0; i < NN; i++) acc_q[i] <= '0;
      end

      if (rd_vld_q[RD_LAT-1] && (state_q == S_INIT)) begin
        for (int i = 0; i < NN; i++)
          if (rd_tag_q[RD_LAT-1] == TAG_W'(i)) acc_q[i] <= ACC_W'(bus.BRAM_RDDATA);
      end

      if (rd_vld_q[RD_LAT-1] && (state_q == S_LOAD)) begin
        for (int i = 0; i < N; i++) begin
          if (rd_tag_q[RD_LAT-1] == TAG_W'(i))     a_q[i] <= operand(bus.BRAM_RDDATA);
          if (rd_tag_q[RD_LAT-1] == TAG_W'(N + i)) b_q[i] <= operand(bus.BRAM_RDDATA);
        end
      end

      if (state_q == S_MAC) begin
        for (int i = 0; i < NN; i++)
          acc_q[i] <= acc_q[i] + mac_term(a_q[i / N], b_q[i % N]);
      end
    end
  end

  // Outputs; the BRAM bus idles at zero whenever nothing is issued
  always_comb begin
    bus.busy        = (state_q != S_IDLE);
    bus.done        = (state_q == S_DONE);
    bus.err         = (state_q == S_DONE) && err_q;
    bus.BRAM_ADDR   = '0;
    bus.BRAM_WE     = '0;
    bus.BRAM_WRDATA = '0;
    if (rd_issue) begin
      bus.BRAM_ADDR = {addr_w, 2'b00};
    end
    if (state_q == S_WRITE) begin
      bus.BRAM_ADDR   = {addr_w, 2'b00};
      bus.BRAM_WE     = {BRAM_WE_WIDTH{1'b1}};
      bus.BRAM_WRDATA = BRAM_DATA_WIDTH'(acc_q[cnt_q[TAG_W-1:0]]);
    end
  end

endmodule

// File: doc/my_gemm_tile.md
Name: my_gemm_tile

Overview:
- Parametrised successor to the fixed 8x8 PE-array controller: N x N output-stationary integer MAC array computing C = A*B, or C += A*B in accumulate mode.
- A is N x K and B is K x N; K is a run-time input.
- A, B and C live in one BRAM at run-time base addresses; the block sits behind the AXI start/done slave, with the BRAM port as its only data path.

Parameters:
- N, 8, tile edge (PE array is N x N), N >= 2
- DATA_W, 16, signed operand width (low DATA_W bits of each BRAM word)
- ACC_W, 32, accumulator width, must equal BRAM_DATA_WIDTH
- K_W, 16, width of k_len
- RD_LAT, 1, BRAM read latency in cycles
- DONE_LENGTH, 5, done pulse duration
- BRAM_ADDR_WIDTH, 32; BRAM_DATA_WIDTH, 32; BRAM_WE_WIDTH, 4

Ports:
- S_AXI_ACLK  in  1  sole clock
- S_AXI_ARESET  in  1  asynchronous reset, active-high
- start  in  1  request; accepted only in IDLE
- k_len  in  K_W  inner dimension K
- a_base, b_base, c_base  in  BRAM_ADDR_WIDTH-2  word base addresses
- mode_acc  in  1  1: C preloaded into accumulators
- busy  out  1  high in every state except IDLE
- done  out  1  high DONE_LENGTH cycles at end
- err  out  1  high with done when k_len was 0
- BRAM_ADDR  out  BRAM_ADDR_WIDTH  byte address = word address << 2
- BRAM_RDDATA  in  BRAM_DATA_WIDTH  read data
- BRAM_WRDATA  out  BRAM_DATA_WIDTH  write data
- BRAM_WE  out  BRAM_WE_WIDTH  byte enables
- BRAM_CLK  out  1  equals S_AXI_ACLK

Behaviour:
- Reset (async, any state): state IDLE; busy, done, err, BRAM_WE, BRAM_ADDR and BRAM_WRDATA all 0; accumulators and counters cleared. An in-flight job is abandoned with no further writes.
- Job parameters are latched on start in IDLE. start while busy is ignored, and later input changes do not affect the running job.
- Layout (word addresses):
  - A[r][k] = a_base + r*K + k
  - B[k][c] = b_base + k*N + c
  - C[r][c] = c_base + r*N + c
- Operands are sign-extended from DATA_W. Accumulation is two's-complement, wrapping at ACC_W (no saturation).
- States:
  - IDLE -> INIT when mode_acc=1, -> LOAD when mode_acc=0 (accumulators zeroed), -> DONE with err=1 when k_len=0 (no BRAM access).
  - INIT: issues N*N reads of C in row-major order, one per cycle. Data returning RD_LAT cycles later loads acc[r][c]. Lasts N*N+RD_LAT cycles, then -> LOAD.
  - LOAD (step k): issues 2N reads, one per cycle: A[0..N-1][k], then B[k][0..N-1]. Returned words fill the a/b operand buffers. Lasts 2N+RD_LAT cycles, then -> MAC.
  - MAC: one cycle; every acc[r][c] += a[r]*b[c]. Then k+1 < K -> LOAD, else -> WRITE.
  - WRITE: N*N cycles, index i = r*N+c. BRAM_ADDR = (c_base+i)<<2, BRAM_WRDATA = acc[r][c], BRAM_WE all ones. Then -> DONE.
  - DONE: done=1 for DONE_LENGTH cycles (err held alongside when set), then -> IDLE. err clears on leaving DONE.
- Outside WRITE: BRAM_WE=0 and BRAM_WRDATA=0. BRAM_ADDR=0 in IDLE, DONE, MAC and read-drain cycles.
- Latency from the start-accept edge to the first done cycle: (mode_acc ? N*N+RD_LAT : 0) + K*(2N+RD_LAT+1) + N*N cycles.
- K=1 is valid (outer product). K up to 2^K_W-1; address arithmetic wraps at BRAM_ADDR_WIDTH-2 bits.

Test Plan:
- N=2, RD_LAT=1, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], mode_acc=0 -> C=[[19,22],[43,50]] written to c_base..c_base+3; first done 16 cycles after start accept; done high exactly 5 cycles.
- Same operands, mode_acc=1, C preloaded to all 1 -> C=[[20,23],[44,51]]; latency 21 cycles.
- N=2, K=2, all A and B = -32768 (0x8000) -> every C word 0x80000000 (wrap, no saturation).
- k_len=0 -> no BRAM_WE ever asserted, no reads issued; done and err high for 5 cycles, one cycle after start accept.
- S_AXI_ARESET pulsed mid-LOAD of step 1 -> same cycle busy=0, BRAM_WE=0; no C writes follow; next start runs scenario 1 correctly.
- start re-asserted during MAC/WRITE with different k_len and c_base -> ignored; results and addresses match the first job only.
